// File: rtl/port_share_arbiter.sv
// Round-robin owner arbiter for a shared (C, D) input pair, registered grant/data mux.
// Define ARB_TIMEOUT_EN to enable the MAX_HOLD forced release and timeout_pulse.
module port_share_arbiter #(
  parameter  int N        = 4,
  parameter  int HOLD_W   = 4,
  parameter  int MAX_HOLD = 8,
  localparam int OW       = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic [N-1:0]  req_c,
  input  logic [N-1:0]  req_d,
  output logic [N-1:0]  grant,
  output logic [OW-1:0] owner,
  output logic          busy,
  output logic          shared_c,
  output logic          shared_d,
  output logic          timeout_pulse
);

  typedef enum logic [1:0] {IDLE, OWN, RELEASE} state_t;

  state_t              state_q;
  logic [OW-1:0]       ptr_q;
  logic [OW-1:0]       owner_q;
  logic [HOLD_W-1:0]   hold_cnt_q;
  logic [N-1:0]        grant_q;
  logic                busy_q;
  logic                shared_c_q;
  logic                shared_d_q;
  logic                pulse_q;

  logic [OW-1:0]       pick;
  logic [N-1:0]        pick_onehot;
  logic [OW:0]         cand_sum;
  logic [OW-1:0]       ptr_d;
  logic                owner_req;
  logic                timeout_hit;

`ifdef ARB_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;

  if (MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W)) begin : g_max_hold_check
    $error("port_share_arbiter: MAX_HOLD must lie in 1..2**HOLD_W");
  end
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  // Scan from ptr upwards with wrap; walking i downwards lets the lowest offset win.
  always_comb begin
    pick     = '0;
    cand_sum = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand_sum = {1'b0, ptr_q} + (OW + 1)'(i);
      if (cand_sum >= (OW + 1)'(N)) begin
        cand_sum = cand_sum - (OW + 1)'(N);
      end
      if (req[cand_sum[OW-1:0]]) begin
        pick = cand_sum[OW-1:0];
      end
    end
  end

  always_comb begin
    pick_onehot       = '0;
    pick_onehot[pick] = 1'b1;
  end

  assign owner_req   = req[owner_q];
  assign ptr_d       = (owner_q == OW'(N - 1)) ? '0 : owner_q + 1'b1;
  assign timeout_hit = TIMEOUT_EN && owner_req && (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      hold_cnt_q <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      shared_c_q <= 1'b0;
      shared_d_q <= 1'b0;
      pulse_q    <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            state_q    <= OWN;
            grant_q    <= pick_onehot;
            owner_q    <= pick;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
            shared_c_q <= req_c[pick];
            shared_d_q <= req_d[pick];
          end
        end
        OWN: begin
          if (!owner_req || timeout_hit) begin
            state_q    <= RELEASE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            shared_c_q <= 1'b0;
            shared_d_q <= 1'b0;
            ptr_q      <= ptr_d;
            pulse_q    <= timeout_hit;
          end else begin
            shared_c_q <= req_c[owner_q];
            shared_d_q <= req_d[owner_q];
            if (hold_cnt_q != {HOLD_W{1'b1}}) begin
              hold_cnt_q <= hold_cnt_q + 1'b1;
            end
          end
        end
        // One forced grant-free cycle before the next arbitration.
        RELEASE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign grant         = grant_q;
  assign owner         = owner_q;
  assign busy          = busy_q;
  assign shared_c      = shared_c_q;
  assign shared_d      = shared_d_q;
  assign timeout_pulse = pulse_q & TIMEOUT_EN;

endmodule

// File: tb/tb_port_share_arbiter.sv
// Directed-vector scoreboard bench for port_share_arbiter (N=4 main instance, N=3 wrap instance).
module tb_port_share_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, rc, rd;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy, sc, sd, tp;

  logic [2:0] req3, rc3, rd3;
  logic [2:0] grant3;
  logic [1:0] owner3;
  logic       busy3, sc3, sd3, tp3;

  typedef struct {
    logic [9:0] v;
    int         id;
  } exp_t;

  exp_t q4[$];
  exp_t q3[$];
  exp_t e4, e3;
  logic [9:0] a4, a3;
  int checks = 0;
  int errors = 0;
  int row_id = 0;

  always #5 clk = ~clk;

  port_share_arbiter #(.N(4), .HOLD_W(4), .MAX_HOLD(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_c(rc), .req_d(rd),
    .grant(grant), .owner(owner), .busy(busy), .shared_c(sc), .shared_d(sd),
    .timeout_pulse(tp)
  );

  port_share_arbiter #(.N(3), .HOLD_W(4), .MAX_HOLD(8)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .req_c(rc3), .req_d(rd3),
    .grant(grant3), .owner(owner3), .busy(busy3), .shared_c(sc3), .shared_d(sd3),
    .timeout_pulse(tp3)
  );

  // Monitor: each row's expectation is due just after the rising edge that samples it.
  always @(posedge clk) begin
    #2;
    if (q4.size() > 0) begin
      e4 = q4.pop_front();
      a4 = {grant, busy, owner, sc, sd, tp};
      checks++;
      if (a4 !== e4.v) begin
        errors++;
        $display("FAIL row%0d main: got grant=%b busy=%b owner=%0d c=%b d=%b tp=%b, need grant=%b busy=%b owner=%0d c=%b d=%b tp=%b",
                 e4.id, a4[9:6], a4[5], a4[4:3], a4[2], a4[1], a4[0],
                 e4.v[9:6], e4.v[5], e4.v[4:3], e4.v[2], e4.v[1], e4.v[0]);
      end
    end
    if (q3.size() > 0) begin
      e3 = q3.pop_front();
      a3 = {1'b0, grant3, busy3, owner3, sc3, sd3, tp3};
      checks++;
      if (a3 !== e3.v) begin
        errors++;
        $display("FAIL row%0d n3: got grant=%b busy=%b owner=%0d c=%b d=%b tp=%b, need grant=%b busy=%b owner=%0d c=%b d=%b tp=%b",
                 e3.id, a3[9:6], a3[5], a3[4:3], a3[2], a3[1], a3[0],
                 e3.v[9:6], e3.v[5], e3.v[4:3], e3.v[2], e3.v[1], e3.v[0]);
      end
    end
  end

  task automatic step(input bit sel, input logic r, input logic [3:0] rq, input logic [3:0] cc,
                      input logic [3:0] dd, input logic [3:0] g, input logic b,
                      input logic [1:0] o, input logic esc, input logic esd, input logic etp);
    exp_t e;
    logic was;
    @(negedge clk);
    #1;
    row_id++;
    was   = rst_n;
    rst_n = r;
    if (sel) begin
      req3 = rq[2:0];
      rc3  = cc[2:0];
      rd3  = dd[2:0];
    end else begin
      req = rq;
      rc  = cc;
      rd  = dd;
    end
    e.v  = {g, b, o, esc, esd, etp};
    e.id = row_id;
    if (sel) q3.push_back(e);
    else     q4.push_back(e);
    if (was && !r) begin
      #1;
      checks++;
      if ({grant, busy, owner, sc, sd, tp} !== 10'b0) begin
        errors++;
        $display("FAIL async_reset row%0d: got grant=%b busy=%b owner=%0d c=%b d=%b tp=%b, need all zero",
                 row_id, grant, busy, owner, sc, sd, tp);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    req = '0; rc = '0; rd = '0;
    req3 = '0; rc3 = '0; rd3 = '0;
    #2 rst_n = 1'b0;

    // Reset held with all requests up, then first grant from ptr=0
    repeat (3) step(0, 0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0, 0);
    // Rotation 0 -> 1 -> 2 -> 3 -> 0
    step(0, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0, 0);
    step(0, 1, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0, 0, 0);
    step(0, 1, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b1000, 1, 2'd3, 0, 0, 0);
    step(0, 1, 4'b0111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 0, 2'd3, 0, 0, 0);
    step(0, 1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0, 0);
    // Data path through requester 2; req_c[0] toggles must not leak
    step(0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 1, 2'd2, 0, 0, 0);
    step(0, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 1, 0, 0);
    step(0, 1, 4'b0100, 4'b0001, 4'b0100, 4'b0100, 1, 2'd2, 0, 1, 0);
    step(0, 1, 4'b0100, 4'b0101, 4'b0100, 4'b0100, 1, 2'd2, 1, 1, 0);
    step(0, 1, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 1, 2'd2, 1, 1, 0);
    step(0, 1, 4'b0000, 4'b0100, 4'b0100, 4'b0000, 0, 2'd2, 0, 0, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 0, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 0, 0);
    // Async reset mid-grant, then arbitration restarts from ptr=0
    step(0, 1, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 2'd1, 1, 1, 0);
    step(0, 1, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 1, 2'd1, 1, 1, 0);
    step(0, 0, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0, 0);
    step(0, 1, 4'b1110, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0, 0);
    step(0, 1, 4'b1100, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0);
    step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0);
    // Long hold with req=0011
    step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0, 0);
`ifdef ARB_TIMEOUT_EN
    repeat (7) step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0, 0);
    step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 1);
    step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0, 0);
    repeat (7) step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1, 2'd1, 0, 0, 0);
    // Owner drops req on the would-be timeout edge: plain release
    step(0, 1, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd1, 0, 0, 0);
`else
    repeat (19) step(0, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1, 2'd0, 0, 0, 0);
    step(0, 1, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(0, 1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 2'd0, 0, 0, 0);
`endif
    // N=3 pointer wrap: owner 2 is followed by owner 0
    step(1, 1, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 1, 2'd2, 1, 0, 0);
    step(1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 0, 0);
    step(1, 1, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 0, 2'd2, 0, 0, 0);
    step(1, 1, 4'b0111, 4'b0000, 4'b0001, 4'b0001, 1, 2'd0, 0, 1, 0);
    step(1, 1, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(1, 1, 4'b0110, 4'b0000, 4'b0001, 4'b0000, 0, 2'd0, 0, 0, 0);
    step(1, 1, 4'b0110, 4'b0000, 4'b0001, 4'b0010, 1, 2'd1, 0, 0, 0);

    repeat (3) @(posedge clk);
    #5;
    checks++;
    if (q4.size() != 0 || q3.size() != 0) begin
      errors++;
      $display("FAIL drain: pending main=%0d n3=%0d, need 0 and 0", q4.size(), q3.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
